// File: rtl/pifo_rank_queue.sv
// pifo_rank_queue: sorted shift-register PIFO (lowest rank first, FIFO on ties)
// with same-cycle insert+pop and a rank-threshold pause gate on the pop side.
module pifo_rank_queue #(
    parameter int DEPTH          = 16,
    parameter int RANK_WIDTH     = 18,
    parameter int META_WIDTH     = 12,
    parameter int ALMOST_FULL_ON = 12,
    parameter int CNT_WIDTH      = 5
) (
    input  logic                  axis_aclk,
    input  logic                  axis_reset,
    input  logic                  s_insert_valid,
    output logic                  s_insert_ready,
    input  logic [RANK_WIDTH-1:0] s_insert_rank,
    input  logic [META_WIDTH-1:0] s_insert_meta,
    output logic                  m_pop_valid,
    input  logic                  m_pop_ready,
    output logic [RANK_WIDTH-1:0] m_pop_rank,
    output logic [META_WIDTH-1:0] m_pop_meta,
    input  logic                  s_pause_valid,
    input  logic [RANK_WIDTH-1:0] s_pause_rank,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  almost_full
);
    localparam int EW = 1 + RANK_WIDTH + META_WIDTH;

    // Entry layout: {valid, rank, meta}; an invalid entry is all zeros.
    logic [EW-1:0]         e_q [DEPTH];
    logic [EW-1:0]         e_d [DEPTH];
    logic [EW-1:0]         up  [DEPTH];
    logic [EW-1:0]         dn  [DEPTH];
    logic [EW-1:0]         new_e;
    logic [DEPTH+1:0]      le;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  full_q, af_q;
    logic [RANK_WIDTH-1:0] pause_q;
    logic                  ins, pop;

    assign new_e          = {1'b1, s_insert_rank, s_insert_meta};
    assign s_insert_ready = !full_q;
    assign ins            = s_insert_valid & !full_q;
    assign m_pop_rank     = e_q[0][EW-2 -: RANK_WIDTH];
    assign m_pop_meta     = e_q[0][META_WIDTH-1:0];
    assign m_pop_valid    = e_q[0][EW-1] & ((&pause_q) | (m_pop_rank < pause_q));
    assign pop            = m_pop_valid & m_pop_ready;
    assign count          = cnt_q;
    assign full           = full_q;
    assign almost_full    = af_q;
    assign cnt_d          = cnt_q + CNT_WIDTH'(ins) - CNT_WIDTH'(pop);

    // le[i+1] marks entry i as ahead of the new entry; the array is sorted, so le is a
    // prefix mask and the insert slot p is where it first drops. le[0]/le[DEPTH+1] are guards.
    always_comb begin
        le     = '0;
        le[0]  = 1'b1;
        up[DEPTH-1] = '0;
        dn[0]  = '0;
        for (int i = 0; i < DEPTH; i++)
            le[i+1] = e_q[i][EW-1] && (e_q[i][EW-2 -: RANK_WIDTH] <= s_insert_rank);
        for (int i = 0; i < DEPTH - 1; i++) begin
            up[i]   = e_q[i+1];
            dn[i+1] = e_q[i];
        end
        for (int i = 0; i < DEPTH; i++)
            e_d[i] = (ins && pop) ? (le[i+2] ? up[i] : (le[i+1] || i == 0) ? new_e : e_q[i])
                   : ins          ? (le[i+1] ? e_q[i] : le[i] ? new_e : dn[i])
                   : pop          ? up[i]
                   :                e_q[i];
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            for (int i = 0; i < DEPTH; i++)
                e_q[i] <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            pause_q <= '1;
        end else begin
            e_q    <= e_d;
            cnt_q  <= cnt_d;
            full_q <= cnt_d == CNT_WIDTH'(DEPTH);
            af_q   <= cnt_d >= CNT_WIDTH'(ALMOST_FULL_ON);
            if (s_pause_valid)
                pause_q <= s_pause_rank;
        end
    end
endmodule

// File: tb/tb_pifo_rank_queue.sv
// tb_pifo_rank_queue: directed stimulus; expected pops go to a scoreboard queue
// checked by an independent monitor, plus direct status checks.
module tb_pifo_rank_queue;
    localparam int RW = 18;
    localparam int MW = 12;
    localparam int D  = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_insert_valid = 1'b0;
    logic          s_insert_ready;
    logic [RW-1:0] s_insert_rank = '0;
    logic [MW-1:0] s_insert_meta = '0;
    logic          m_pop_valid;
    logic          m_pop_ready = 1'b0;
    logic [RW-1:0] m_pop_rank;
    logic [MW-1:0] m_pop_meta;
    logic          s_pause_valid = 1'b0;
    logic [RW-1:0] s_pause_rank = '0;
    logic [CW-1:0] count;
    logic          full;
    logic          almost_full;

    logic [RW+MW-1:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pifo_rank_queue #(
        .DEPTH(D), .RANK_WIDTH(RW), .META_WIDTH(MW), .ALMOST_FULL_ON(12), .CNT_WIDTH(CW)
    ) dut (
        .axis_aclk(clk),
        .axis_reset(rst),
        .s_insert_valid(s_insert_valid),
        .s_insert_ready(s_insert_ready),
        .s_insert_rank(s_insert_rank),
        .s_insert_meta(s_insert_meta),
        .m_pop_valid(m_pop_valid),
        .m_pop_ready(m_pop_ready),
        .m_pop_rank(m_pop_rank),
        .m_pop_meta(m_pop_meta),
        .s_pause_valid(s_pause_valid),
        .s_pause_rank(s_pause_rank),
        .count(count),
        .full(full),
        .almost_full(almost_full)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input int r, input int m);
        s_insert_valid = 1'b1;
        s_insert_rank  = RW'(r);
        s_insert_meta  = MW'(m);
        tick();
        s_insert_valid = 1'b0;
    endtask

    task automatic pop(input int r, input int m);
        exp_q.push_back({RW'(r), MW'(m)});
        m_pop_ready = 1'b1;
        tick();
        m_pop_ready = 1'b0;
    endtask

    task automatic ins_pop(input int ri, input int mi, input int rp, input int mp);
        exp_q.push_back({RW'(rp), MW'(mp)});
        s_insert_valid = 1'b1;
        s_insert_rank  = RW'(ri);
        s_insert_meta  = MW'(mi);
        m_pop_ready    = 1'b1;
        tick();
        s_insert_valid = 1'b0;
        m_pop_ready    = 1'b0;
    endtask

    task automatic pause(input logic [RW-1:0] r);
        s_pause_valid = 1'b1;
        s_pause_rank  = r;
        tick();
        s_pause_valid = 1'b0;
    endtask

    // Monitor: every pop handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && m_pop_valid && m_pop_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pop: got rank %0d meta %0d, none expected", m_pop_rank, m_pop_meta);
            end else begin
                logic [RW+MW-1:0] e;
                e = exp_q.pop_front();
                check("pop_rank", 32'(m_pop_rank), 32'(e[RW+MW-1:MW]));
                check("pop_meta", 32'(m_pop_meta), 32'(e[MW-1:0]));
            end
        end
    end

    initial begin
        #12 rst = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_ready", 32'(s_insert_ready), 1);
        check("rst_valid", 32'(m_pop_valid), 0);
        check("rst_rank", 32'(m_pop_rank), 0);
        check("rst_meta", 32'(m_pop_meta), 0);
        check("rst_full", 32'(full), 0);
        check("rst_afull", 32'(almost_full), 0);
        tick();

        // Ordering with FIFO tie-break
        ins(5, 1); ins(3, 2); ins(9, 3); ins(3, 4);
        check("ord_count", 32'(count), 4);
        check("ord_head", 32'(m_pop_rank), 3);
        pop(3, 2); pop(3, 4); pop(5, 1); pop(9, 3);
        check("ord_count_end", 32'(count), 0);
        check("ord_valid_end", 32'(m_pop_valid), 0);
        check("ord_drain", 32'(exp_q.size()), 0);

        // Almost-full / full / blocked insert
        for (int i = 0; i < 11; i++) ins(10 + i, i + 1);
        check("af_at_11", 32'(almost_full), 0);
        ins(21, 12);
        check("af_at_12", 32'(almost_full), 1);
        check("count_12", 32'(count), 12);
        for (int i = 12; i < 16; i++) ins(10 + i, i + 1);
        check("full", 32'(full), 1);
        check("ready_full", 32'(s_insert_ready), 0);
        ins(0, 99);
        check("full_count", 32'(count), 16);
        check("full_head_rank", 32'(m_pop_rank), 10);
        check("full_head_meta", 32'(m_pop_meta), 1);
        for (int i = 0; i < 16; i++) pop(10 + i, i + 1);
        check("full_drain", 32'(exp_q.size()), 0);
        check("full_empty", 32'(count), 0);

        // Simultaneous insert + pop
        ins(2, 2); ins(4, 4); ins(6, 6);
        ins_pop(5, 5, 2, 2);
        check("sim_count", 32'(count), 3);
        check("sim_head", 32'(m_pop_rank), 4);
        ins_pop(1, 1, 4, 4);
        check("sim0_count", 32'(count), 3);
        check("sim0_head", 32'(m_pop_rank), 1);
        pop(1, 1); pop(5, 5); pop(6, 6);
        check("sim_drain", 32'(exp_q.size()), 0);

        // Pause gate
        ins(3, 30); ins(8, 80);
        pause(RW'(5));
        check("pause_valid3", 32'(m_pop_valid), 1);
        pop(3, 30);
        check("pause_blocked", 32'(m_pop_valid), 0);
        check("pause_head8", 32'(m_pop_rank), 8);
        ins(4, 40);
        check("pause_valid4", 32'(m_pop_valid), 1);
        check("pause_head4", 32'(m_pop_rank), 4);
        pop(4, 40);
        check("pause_blocked2", 32'(m_pop_valid), 0);
        pause('1);
        check("unpause_valid", 32'(m_pop_valid), 1);
        pop(8, 80);
        check("pause_drain", 32'(exp_q.size()), 0);
        check("pause_count", 32'(count), 0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 7; i++) ins(20 + i, i);
        check("pre_rst_count", 32'(count), 7);
        #2 rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_valid", 32'(m_pop_valid), 0);
        check("arst_rank", 32'(m_pop_rank), 0);
        check("arst_meta", 32'(m_pop_meta), 0);
        check("arst_ready", 32'(s_insert_ready), 1);
        #3 rst = 1'b0;
        tick();
        ins(1, 7);
        check("post_rst_valid", 32'(m_pop_valid), 1);
        check("post_rst_head", 32'(m_pop_rank), 1);
        check("post_rst_count", 32'(count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
